// File: rtl/sc_shiftseq_pkg.sv
// Shared types and constants for the player-car shift sequencer.
// State encoding is fixed because it is exported on the debug bus.
package sc_shiftseq_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    INIT     = 3'd1,
    WAIT     = 3'd2,
    SHIFT    = 3'd3,
    COOLDOWN = 3'd4,
    HALT     = 3'd5
  } state_t;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  // A single-cycle cooldown still needs a 1-bit counter.
  function automatic int cnt_width(input int cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/sc_button_edge.sv
// Two-flop synchronizer for an active-low button plus a registered
// falling-edge detector: one clean pulse per press, none while held.
module sc_button_edge (
  input  logic SC_RegSHIFTER_CLOCK_50,
  input  logic SC_RegSHIFTER_RESET_InHigh,
  input  logic btn_InLow,
  output logic pulse_Out
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic hist_q,  hist_d;
  logic pulse_q, pulse_d;

  always_comb begin
    sync1_d = btn_InLow;
    sync2_d = sync1_q;
    hist_d  = sync2_q;
    pulse_d = hist_q & ~sync2_q;
  end

  // NOTE: flops use non-blocking assignments so every register samples the
  // pre-edge value of its neighbour; blocking here would collapse the chain.
  always_ff @(posedge SC_RegSHIFTER_CLOCK_50 or posedge SC_RegSHIFTER_RESET_InHigh) begin
    if (SC_RegSHIFTER_RESET_InHigh) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      hist_q  <= 1'b1;
      pulse_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      hist_q  <= hist_d;
      pulse_q <= pulse_d;
    end
  end

  assign pulse_Out = pulse_q;

endmodule

// File: rtl/sc_shift_sequencer.sv
// Owns the car position register and sequences the external shifter:
// start/left/right requests, edge protection, cooldown and crash halt.
module sc_shift_sequencer
  import sc_shiftseq_pkg::*;
#(
  parameter int DATAWIDTH       = 8,
  parameter int COOLDOWN_CYCLES = 12_500_000
) (
  input  logic                 SC_RegSHIFTER_CLOCK_50,
  input  logic                 SC_RegSHIFTER_RESET_InHigh,
  input  logic                 SC_ShiftSEQ_startButton_InLow,
  input  logic                 SC_ShiftSEQ_leftButton_InLow,
  input  logic                 SC_ShiftSEQ_rightButton_InLow,
  input  logic                 SC_ShiftSEQ_crash_InHigh,
  input  logic [DATAWIDTH-1:0] SC_ShiftSEQ_shifted_InBUS,
  output logic [DATAWIDTH-1:0] SC_ShiftSEQ_data_OutBUS,
  output logic                 SC_ShiftSEQ_dir_Out,
  output logic                 SC_ShiftSEQ_shiftStrobe_Out,
  output logic                 SC_ShiftSEQ_running_Out,
  output logic [2:0]           SC_ShiftSEQ_state_OutBUS
);

  localparam int                   CNT_W    = cnt_width(COOLDOWN_CYCLES);
  localparam logic [CNT_W-1:0]     CNT_LOAD = CNT_W'(COOLDOWN_CYCLES - 1);
  localparam logic [DATAWIDTH-1:0] CENTER   = DATAWIDTH'(1) << (DATAWIDTH / 2);

  logic start_pulse, left_pulse, right_pulse;

  sc_button_edge u_start (
    .SC_RegSHIFTER_CLOCK_50    (SC_RegSHIFTER_CLOCK_50),
    .SC_RegSHIFTER_RESET_InHigh(SC_RegSHIFTER_RESET_InHigh),
    .btn_InLow                 (SC_ShiftSEQ_startButton_InLow),
    .pulse_Out                 (start_pulse)
  );

  sc_button_edge u_left (
    .SC_RegSHIFTER_CLOCK_50    (SC_RegSHIFTER_CLOCK_50),
    .SC_RegSHIFTER_RESET_InHigh(SC_RegSHIFTER_RESET_InHigh),
    .btn_InLow                 (SC_ShiftSEQ_leftButton_InLow),
    .pulse_Out                 (left_pulse)
  );

  sc_button_edge u_right (
    .SC_RegSHIFTER_CLOCK_50    (SC_RegSHIFTER_CLOCK_50),
    .SC_RegSHIFTER_RESET_InHigh(SC_RegSHIFTER_RESET_InHigh),
    .btn_InLow                 (SC_ShiftSEQ_rightButton_InLow),
    .pulse_Out                 (right_pulse)
  );

  state_t               state_q, state_d;
  logic [DATAWIDTH-1:0] pos_q,   pos_d;
  logic                 dir_q,   dir_d;
  logic [CNT_W-1:0]     cnt_q,   cnt_d;
  logic                 active;

  assign active = (state_q == WAIT) || (state_q == SHIFT) || (state_q == COOLDOWN);

  // NOTE: every signal gets a default before the case so that no path leaves
  // it unassigned; a missing default here would infer a latch.
  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    dir_d   = dir_q;
    cnt_d   = cnt_q;

    if (active && SC_ShiftSEQ_crash_InHigh) begin
      state_d = HALT;
    end else begin
      unique case (state_q)
        IDLE, HALT: if (start_pulse) state_d = INIT;
        INIT: begin
          pos_d   = CENTER;
          state_d = WAIT;
        end
        // Simultaneous left/right cancel; edge-bit requests are dropped.
        WAIT: begin
          if (left_pulse && !right_pulse && !pos_q[DATAWIDTH-1]) begin
            dir_d   = DIR_LEFT;
            state_d = SHIFT;
          end else if (right_pulse && !left_pulse && !pos_q[0]) begin
            dir_d   = DIR_RIGHT;
            state_d = SHIFT;
          end
        end
        SHIFT: begin
          pos_d   = SC_ShiftSEQ_shifted_InBUS;
          cnt_d   = CNT_LOAD;
          state_d = COOLDOWN;
        end
        COOLDOWN: begin
          if (cnt_q == '0) state_d = WAIT;
          else             cnt_d   = cnt_q - CNT_W'(1);
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge SC_RegSHIFTER_CLOCK_50 or posedge SC_RegSHIFTER_RESET_InHigh) begin
    if (SC_RegSHIFTER_RESET_InHigh) begin
      state_q <= IDLE;
      pos_q   <= '0;
      dir_q   <= DIR_LEFT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      dir_q   <= dir_d;
      cnt_q   <= cnt_d;
    end
  end

  assign SC_ShiftSEQ_data_OutBUS     = pos_q;
  assign SC_ShiftSEQ_dir_Out         = dir_q;
  assign SC_ShiftSEQ_shiftStrobe_Out = (state_q == SHIFT);
  assign SC_ShiftSEQ_running_Out     = active;
  assign SC_ShiftSEQ_state_OutBUS    = state_q;

endmodule

// File: tb/tb_sc_shift_sequencer.sv
// Scoreboard bench for sc_shift_sequencer: a car-position model predicts each
// accepted move; a monitor checks every strobe and the committed position.
module tb_sc_shift_sequencer;
  import sc_shiftseq_pkg::*;

  localparam int DW = 8;
  localparam int CD = 4;

  logic          clk     = 1'b0;
  logic          rst     = 1'b1;
  logic          start_n = 1'b1;
  logic          left_n  = 1'b1;
  logic          right_n = 1'b1;
  logic          crash   = 1'b0;
  logic [DW-1:0] shifted;
  logic [DW-1:0] data;
  logic          dir, strobe, running;
  logic [2:0]    state;

  always #10 clk = ~clk;

  // Behavioural shifter stage.
  assign shifted = dir ? (data >> 1) : (data << 1);

  sc_shift_sequencer #(.DATAWIDTH(DW), .COOLDOWN_CYCLES(CD)) dut (
    .SC_RegSHIFTER_CLOCK_50       (clk),
    .SC_RegSHIFTER_RESET_InHigh   (rst),
    .SC_ShiftSEQ_startButton_InLow(start_n),
    .SC_ShiftSEQ_leftButton_InLow (left_n),
    .SC_ShiftSEQ_rightButton_InLow(right_n),
    .SC_ShiftSEQ_crash_InHigh     (crash),
    .SC_ShiftSEQ_shifted_InBUS    (shifted),
    .SC_ShiftSEQ_data_OutBUS      (data),
    .SC_ShiftSEQ_dir_Out          (dir),
    .SC_ShiftSEQ_shiftStrobe_Out  (strobe),
    .SC_ShiftSEQ_running_Out      (running),
    .SC_ShiftSEQ_state_OutBUS     (state)
  );

  typedef struct {
    logic          dir;
    logic [DW-1:0] data_after;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   model_idx;   // bit index of the car

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every strobe must match a queued move; the position is checked
  // in the following cycle.
  exp_t pend;
  bit   pend_v = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      pend_v = 1'b0;
    end else begin
      if (pend_v) begin
        check("mon_data", 32'(data), 32'(pend.data_after));
        pend_v = 1'b0;
      end
      if (strobe) begin
        if (exp_q.size() == 0) begin
          check("mon_unexpected_strobe", 32'(strobe), 32'd0);
        end else begin
          pend = exp_q.pop_front();
          check("mon_dir", 32'(dir), 32'(pend.dir));
          pend_v = 1'b1;
        end
      end
    end
  end

  task automatic model_move(input bit go_right);
    exp_t e;
    if (!go_right && model_idx < DW - 1) begin
      model_idx++;
      e.dir = 1'b0; e.data_after = DW'(1) << model_idx;
      exp_q.push_back(e);
    end else if (go_right && model_idx > 0) begin
      model_idx--;
      e.dir = 1'b1; e.data_after = DW'(1) << model_idx;
      exp_q.push_back(e);
    end
  endtask

  task automatic press(input bit l, input bit r, input int hold);
    @(posedge clk); #1;
    left_n = ~l; right_n = ~r;
    repeat (hold) @(posedge clk);
    #1;
    left_n = 1'b1; right_n = 1'b1;
  endtask

  task automatic press_start();
    @(posedge clk); #1 start_n = 1'b0;
    @(posedge clk); #1 start_n = 1'b1;
  endtask

  task automatic do_move(input bit go_right, input int hold);
    model_move(go_right);
    press(!go_right, go_right, hold);
    repeat (14 + $urandom_range(0, 3)) @(posedge clk);
  endtask

  task automatic wait_strobe(input int max, output int cyc);
    cyc = -1;
    for (int i = 1; i <= max; i++) begin
      @(negedge clk);
      if (strobe) begin
        cyc = i;
        break;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   c;
    logic [5:0] mask;
    exp_t e;

    // 1. Reset and start
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_state",   32'(state),   32'(IDLE));
    check("rst_data",    32'(data),    32'h00);
    check("rst_running", 32'(running), 32'd0);
    check("rst_strobe",  32'(strobe),  32'd0);
    check("rst_dir",     32'(dir),     32'd0);
    rst = 1'b0;
    @(posedge clk); #1 start_n = 1'b0;
    @(negedge clk);
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      if (i == 3) check("start_idle_data", 32'(data), 32'h00);
      if (i == 4) begin
        check("start_init_state", 32'(state), 32'(INIT));
        check("start_init_data",  32'(data),  32'h00);
      end
      if (i == 5) begin
        check("start_center",  32'(data),    32'h10);
        check("start_wait",    32'(state),   32'(WAIT));
        check("start_running", 32'(running), 32'd1);
      end
    end
    start_n = 1'b1;
    model_idx = DW / 2;
    repeat (4) @(posedge clk);

    // 2. Single move with latency; button stays held (no repeat)
    model_move(1'b0);
    mask = '0;
    @(posedge clk); #1 left_n = 1'b0;
    @(negedge clk);
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      mask[i-1] = strobe;
      if (i == 4) check("move_dir", 32'(dir), 32'(DIR_LEFT));
      if (i == 5) check("move_data", 32'(data), 32'h20);
    end
    repeat (8) @(posedge clk);
    check("move_strobe_mask", 32'(mask), 32'b001000);
    check("held_no_repeat",   32'(data), 32'h20);
    #1 left_n = 1'b1;
    repeat (6) @(posedge clk);

    // 3. Boundaries
    do_move(1'b0, 1);
    do_move(1'b0, 2);
    do_move(1'b0, 1);
    @(negedge clk) check("left_edge_hold", 32'(data), 32'h80);
    do_move(1'b1, 1);
    @(negedge clk) check("right_from_edge", 32'(data), 32'h40);
    for (int i = 0; i < 6; i++) do_move(1'b1, 1);
    do_move(1'b1, 1);
    @(negedge clk) check("right_edge_hold", 32'(data), 32'h01);

    // 5. Crash during SHIFT: position frozen, then restart
    e.dir = DIR_LEFT; e.data_after = 8'h01;
    exp_q.push_back(e);
    @(posedge clk); #1 left_n = 1'b0;
    @(posedge clk); #1 left_n = 1'b1;
    wait_strobe(8, c);
    check("crash_strobe_seen", 32'(c > 0), 32'd1);
    crash = 1'b1;
    @(posedge clk); #1 crash = 1'b0;
    check("crash_halt",    32'(state),   32'(HALT));
    check("crash_data",    32'(data),    32'h01);
    check("crash_running", 32'(running), 32'd0);
    press(1'b1, 1'b0, 1);
    repeat (8) @(posedge clk);
    @(negedge clk) check("halt_ignores_move", 32'(data), 32'h01);
    press_start();
    repeat (8) @(posedge clk);
    @(negedge clk);
    check("restart_data",  32'(data),  32'h10);
    check("restart_state", 32'(state), 32'(WAIT));
    model_idx = DW / 2;

    // 4. Press during cooldown is dropped; simultaneous presses cancel
    model_move(1'b0);
    press(1'b1, 1'b0, 1);
    @(posedge clk);
    press(1'b1, 1'b0, 1);
    repeat (14) @(posedge clk);
    @(negedge clk) check("cooldown_drop", 32'(data), 32'h20);
    press(1'b1, 1'b1, 1);
    repeat (14) @(posedge clk);
    @(negedge clk) check("simultaneous_drop", 32'(data), 32'h20);

    // Randomized walk
    for (int i = 0; i < 40; i++)
      do_move(1'($urandom_range(0, 1)), $urandom_range(1, 3));
    @(negedge clk) check("random_walk_pos", 32'(data), 32'(1) << model_idx);

    // 6. Async reset mid-COOLDOWN
    if (model_idx == 0) do_move(1'b0, 1);
    model_move(1'b1);
    press(1'b0, 1'b1, 1);
    wait_strobe(8, c);
    @(posedge clk); #2;
    check("pre_reset_cooldown", 32'(state), 32'(COOLDOWN));
    rst = 1'b1;
    #1;
    check("areset_state",   32'(state),   32'(IDLE));
    check("areset_data",    32'(data),    32'h00);
    check("areset_dir",     32'(dir),     32'd0);
    check("areset_running", 32'(running), 32'd0);
    check("areset_strobe",  32'(strobe),  32'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("post_reset_idle",    32'(state),        32'(IDLE));
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sc_shift_sequencer.md
# sc_shift_sequencer

Controller that sequences the player-car shift register datapath. It owns the car position register, decides when and in which direction the downstream shifter acts, and commits the shifted value back into the position register. It sits between the debounced-free board buttons (start, left, right), the game crash flag, and the combinational shifter stage. Moves are rate-limited by a cooldown timer.

## Interface
- `DATAWIDTH`, 8, width of the position bus; must be ≥ 2.
- `COOLDOWN_CYCLES`, 12_500_000, clock cycles between accepted moves; must be ≥ 1; default is 250 ms at 50 MHz.
- `SC_RegSHIFTER_CLOCK_50`, in, 1, system clock, 50 MHz.
- `SC_RegSHIFTER_RESET_InHigh`, in, 1, reset: asynchronous, active-high.
- `SC_ShiftSEQ_startButton_InLow`, in, 1, start button, asynchronous, active-low.
- `SC_ShiftSEQ_leftButton_InLow`, in, 1, move-left button, asynchronous, active-low.
- `SC_ShiftSEQ_rightButton_InLow`, in, 1, move-right button, asynchronous, active-low.
- `SC_ShiftSEQ_crash_InHigh`, in, 1, collision flag from game logic, synchronous level.
- `SC_ShiftSEQ_shifted_InBUS`, in, DATAWIDTH, shifter result; combinational function of `data_OutBUS` and `dir_Out` in the same cycle.
- `SC_ShiftSEQ_data_OutBUS`, out, DATAWIDTH, current position; feeds the shifter data input and the display.
- `SC_ShiftSEQ_dir_Out`, out, 1, shifter direction: 0 = left (`<<1`), 1 = right (`>>1`).
- `SC_ShiftSEQ_shiftStrobe_Out`, out, 1, high for exactly the SHIFT cycle.
- `SC_ShiftSEQ_running_Out`, out, 1, high in WAIT, SHIFT and COOLDOWN.
- `SC_ShiftSEQ_state_OutBUS`, out, 3, state encoding for debug.

## Operation
**Button conditioning**
- Each button passes through a 2-FF synchronizer followed by a falling-edge detector.
- The detector emits a 1-cycle request pulse per press.
- A button held low produces no repeat pulses.

**States**
- **IDLE**
  - Position = 0.
  - start pulse → INIT.
- **INIT** (1 cycle)
  - Position ← `CENTER = 1 << (DATAWIDTH/2)`.
  - → WAIT.
- **WAIT**
  - Left pulse alone with position[DATAWIDTH-1] = 0: dir = 0 → SHIFT.
  - Right pulse alone with position[0] = 0: dir = 1 → SHIFT.
  - A request at the boundary bit is dropped and the state stays WAIT (no wrap, the car is never lost).
  - Left and right pulses in the same cycle are both dropped.
- **SHIFT** (1 cycle)
  - shiftStrobe = 1.
  - Position ← `shifted_InBUS` at the closing edge.
  - Cooldown counter ← COOLDOWN_CYCLES-1.
  - → COOLDOWN.
- **COOLDOWN**
  - Counter decrements once per cycle.
  - At counter = 0 → WAIT.
  - Left/right pulses arriving here are discarded, not queued.
- **HALT**
  - Position frozen.
  - start pulse → INIT.

**Priorities and general rules**
- Crash = 1 in WAIT, SHIFT or COOLDOWN → HALT on the next edge. Crash has priority over everything.
- Crash during SHIFT: the position is not updated.
- Crash is ignored in IDLE, INIT and HALT.
- Start pulses outside IDLE and HALT are ignored.
- `dir_Out` holds its last value outside SHIFT and resets to 0.
- Position changes only in INIT, in SHIFT, or on reset.

## Timing
- Reset values:
  - State = IDLE.
  - Position = 0.
  - dir = 0, shiftStrobe = 0, running = 0.
  - Counter = 0.
  - Synchronizers and edge registers = 1 (released button).
- Reset mid-operation returns to IDLE immediately (asynchronous). Any pending pulse is lost.
- Request latency: the pulse is high in the 3rd cycle after the first clock edge that samples the pin low.
- The FSM leaves WAIT on the next edge, so SHIFT is the 4th cycle.
- The new position is visible on `data_OutBUS` in the 5th cycle.
- Move period: SHIFT + COOLDOWN_CYCLES cycles, so the earliest next SHIFT is COOLDOWN_CYCLES+4 cycles after the previous SHIFT, given an immediate new press.
- Counter width: `$clog2(COOLDOWN_CYCLES)` bits, minimum 1.
- With COOLDOWN_CYCLES = 1, COOLDOWN lasts one cycle.

## Structure
- Shared package `sc_shiftseq_pkg`:
  - State encoding localparams: IDLE=0, INIT=1, WAIT=2, SHIFT=3, COOLDOWN=4, HALT=5.
  - `DIR_LEFT`=0, `DIR_RIGHT`=1.
- Sub-module `sc_button_edge`:
  - Contents: 2-FF synchronizer and falling-edge pulse.
  - Ports: clock, reset, `btn_InLow`, `pulse_Out`.
  - Instantiated three times.
- The FSM, position register and cooldown counter live in `sc_shift_sequencer`.

## Test plan
Bench uses DATAWIDTH=8, COOLDOWN_CYCLES=4 and a behavioural shifter model.
1. **Reset and start:** reset, then press start → data = 0x00 until INIT; data = 0x10 in the cycle after INIT; running = 1.
2. **Single move:** left press from 0x10 → shiftStrobe high exactly 1 cycle in the 4th cycle; data = 0x20 in the 5th cycle; dir = 0.
3. **Boundary:** from 0x80, press left → no strobe and data stays 0x80. Then press right → data = 0x40. From 0x01, press right → no strobe.
4. **Cooldown drop and simultaneous:** two left presses 2 cycles apart from 0x10 → exactly one shift, to 0x20. Left and right pulses in the same cycle → no strobe.
5. **Crash:** crash asserted during SHIFT → next state HALT and data unchanged. Start → data = 0x10.
6. **Async reset:** reset asserted mid-COOLDOWN, off a clock edge → outputs return to reset values immediately; state = IDLE.
